ifu_pf: RTL and testbench
=========================

// Module: ifu_pf
// PURPOSE
// - Parametrised prefetching instruction fetch unit; sits between instruction memory and the IDU.
// - Fetches whole memory lines ahead of decode into a line buffer, then hands instructions out one per valid/ready handshake.
// - Supports start, branch redirect with flush of stale lines, and WFI stop/resume.
// PARAMETERS
// - ADDR_W    12   byte address width of fetch space
// - INS_W     64   instruction width in bits; power of 2, >=8
// - LINE_W    128  memory line width in bits; power-of-2 multiple of INS_W
// - PC_W      32   width of ifu_idu_pc; must be >= ADDR_W
// - FB_DEPTH  4    line-buffer depth in lines; power of 2, >=2
// - Derived:
//   - SLOTS = LINE_W/INS_W
//   - OFF_W = log2(INS_W/8)
//   - SLOT_W = max(1, log2(SLOTS))
//   - MEM_AW = ADDR_W - log2(LINE_W/8)
// PORTS
// - clk           in   1       clock; all logic rising-edge
// - rst_n         in   1       reset: synchronous, active-low
// - start_vld     in   1       begin fetching at start_addr
// - start_addr    in   ADDR_W  start byte address; low OFF_W bits ignored
// - redir_vld     in   1       branch redirect from ALU
// - redir_addr    in   ADDR_W  redirect byte address; low OFF_W bits ignored
// - wfi           in   1       wait-for-interrupt request from IDU
// - idu_ifu_rdy   in   1       IDU accepts instruction this cycle
// - ifu_idu_vld   out  1       instruction valid
// - ifu_idu_ins   out  INS_W   instruction
// - ifu_idu_pc    out  PC_W    byte PC of ifu_idu_ins, zero-extended
// - mem_ce        out  1       memory read strobe
// - mem_addr      out  MEM_AW  line address
// - mem_dout      in   LINE_W  read data, valid exactly 1 cycle after mem_ce
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge):
//   - state=IDLE; buffer empty; in-flight flag clear.
//   - ifu_idu_vld=0, mem_ce=0, ifu_idu_pc=0, mem_addr=0, ifu_idu_ins=0.
//   - Reset mid-fetch discards the outstanding response.
// - FSM states: IDLE, FETCH, WFI.
//   - IDLE -> FETCH on start_vld.
//   - FETCH -> WFI on wfi.
//   - WFI -> FETCH on start_vld or redir_vld.
//   - redir_vld in IDLE is ignored.
// - Priority within a cycle: reset > start_vld > redir_vld > wfi > normal flow.
// - Start/redirect, in any non-IDLE state (start also from IDLE):
//   - flush buffer; tag any in-flight response as discard.
//   - next line addr = addr[ADDR_W-1:ADDR_W-MEM_AW]; first-slot = addr slot bits.
//   - mem_ce may assert in the same cycle.
// - Request issue:
//   - mem_ce=1 when state==FETCH and occupancy + in-flight < FB_DEPTH; at most 1 outstanding.
//   - Line addr increments by 1 per request and wraps modulo 2^MEM_AW.
// - Response: the cycle after mem_ce, the line is pushed unless tagged discard.
// - Output:
//   - ifu_idu_vld = (state==FETCH) & !empty.
//   - ins = head line slot[cur_slot]; pc = {head_line_addr, cur_slot, OFF_W'b0}.
//   - Output is combinational from registers: zero added latency.
// - Handshake: on vld&rdy, cur_slot++. At slot SLOTS-1 the head pops and cur_slot resets to 0.
// - First line after start/redirect begins at first-slot; lower slots are never presented.
// - Latency: start at cycle T -> ifu_idu_vld=1 at T+2.
// - Full buffer: no request issued; a same-cycle pop frees space for next-cycle issue.
// - WFI:
//   - ifu_idu_vld=0 and no new requests.
//   - An in-flight response still lands; buffer contents are retained but flushed on exit.
// - vld may drop only on flush, WFI, reset or empty. While vld&!rdy, ins/pc stay stable.
// CONFIGURATION
// - IFU_PERF_CNT_EN defined:
//   - Adds out ports perf_ins_cnt[31:0] (accepted handshakes) and perf_stall_cnt[31:0] (cycles vld&!rdy).
//   - Both counters saturate at all-ones and reset to 0.
// - IFU_PERF_CNT_EN undefined: ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
// - Package ifu_pkg: FSM state enum (IDLE/FETCH/WFI), derived-width localparam functions.
// - Sub-module ifu_fetch_buf: FB_DEPTH x (LINE_W+MEM_AW) circular FIFO with push/pop/flush, count and empty/full flags.
// - Top level holds FSM, request credit, slot pointer and output mux.
// TESTING
// - Start: start_addr=0x018, defaults -> pc 0x018, 0x020, 0x028... Line 1 taken from slot 1 only; vld at T+2.
// - Backpressure: rdy=0 for 10 cycles -> ins/pc stable; at most FB_DEPTH lines buffered; no mem_ce while full.
// - Redirect with in-flight response: redir_addr=0x100 -> next accepted pc=0x100; stale line never appears.
// - Wrap: start at 0xFF8 -> pc 0xFF8, then 0x000 (mem_addr 0xFF -> 0x00).
// - WFI: assert wfi mid-stream -> vld=0 next cycle, mem_ce=0. redir_vld to 0x040 -> fetch resumes at 0x040.
// - Reset: rst_n low mid-fetch -> all outputs 0 next cycle; with IFU_PERF_CNT_EN, counters=0.

Source files
------------

// File: rtl/ifu_pf_pkg.sv
//============================================================================
// ifu_pkg : shared types and derived-width helpers for the ifu_pf fetch unit
// Revision : 1.0
//============================================================================
`default_nettype none

package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WFI   = 2'd2
  } ifu_state_e;

  function automatic int off_w(input int ins_w);
    return $clog2(ins_w / 8);
  endfunction

  function automatic int line_byte_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int slot_w(input int line_w, input int ins_w);
    return ($clog2(line_w / ins_w) > 1) ? $clog2(line_w / ins_w) : 1;
  endfunction

  function automatic int mem_aw(input int addr_w, input int line_w);
    return addr_w - $clog2(line_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_pf_fetch_buf.sv
//============================================================================
// ifu_fetch_buf : circular line FIFO with push/pop/flush, count and flags
// Revision : 1.0
//============================================================================
`default_nettype none

module ifu_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 136,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage carries no reset; readers gate on empty_o.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/ifu_pf.sv
//============================================================================
// ifu_pf : prefetching instruction fetch unit (line buffer -> IDU handshake)
// Optional IFU_PERF_CNT_EN adds accepted/stall counters. Revision : 1.0
//============================================================================
`default_nettype none

module ifu_pf
  import ifu_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int INS_W    = 64,
  parameter int LINE_W   = 128,
  parameter int PC_W     = 32,
  parameter int FB_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_vld,
  input  logic [ADDR_W-1:0]                   start_addr,
  input  logic                                redir_vld,
  input  logic [ADDR_W-1:0]                   redir_addr,
  input  logic                                wfi,
  input  logic                                idu_ifu_rdy,
  output logic                                ifu_idu_vld,
  output logic [INS_W-1:0]                    ifu_idu_ins,
  output logic [PC_W-1:0]                     ifu_idu_pc,
  output logic                                mem_ce,
  output logic [mem_aw(ADDR_W, LINE_W)-1:0]   mem_addr,
  input  logic [LINE_W-1:0]                   mem_dout
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_ins_cnt,
  output logic [31:0]                         perf_stall_cnt
`endif
);

  localparam int SLOTS  = LINE_W / INS_W;
  localparam int OFF_W  = off_w(INS_W);
  localparam int LB_W   = line_byte_w(LINE_W);
  localparam int SLOT_W = slot_w(LINE_W, INS_W);
  localparam int MEM_AW = mem_aw(ADDR_W, LINE_W);
  localparam int ENT_W  = LINE_W + MEM_AW;
  localparam int CNT_W  = $clog2(FB_DEPTH) + 1;

  ifu_state_e        state_q, state_d;
  logic [MEM_AW-1:0] line_q, line_d;
  logic [MEM_AW-1:0] req_line_q;
  logic              inflight_q;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic [ADDR_W-1:0] w_tgt_addr;
  logic [MEM_AW-1:0] w_tgt_line;
  logic [SLOT_W-1:0] w_tgt_slot;
  logic              w_flush;
  logic              w_room;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_last;
  logic [ENT_W-1:0]  w_head;
  logic [LINE_W-1:0] w_head_line;
  logic [MEM_AW-1:0] w_head_addr;
  logic [ADDR_W-1:0] w_pc_addr;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;

  ifu_fetch_buf #(
    .DEPTH (FB_DEPTH),
    .WIDTH (ENT_W)
  ) u_fetch_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .data_i  ({req_line_q, mem_dout}),
    .data_o  (w_head),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  always_comb begin
    w_tgt_addr = start_vld ? start_addr : redir_addr;
    w_flush    = start_vld | (redir_vld & (state_q != ST_IDLE));
    w_tgt_line = MEM_AW'(w_tgt_addr >> LB_W);
    w_tgt_slot = SLOT_W'((w_tgt_addr >> OFF_W) & ADDR_W'(SLOTS - 1));

    state_d = state_q;
    if (w_flush) begin
      state_d = ST_FETCH;
    end else if ((state_q == ST_FETCH) && wfi) begin
      state_d = ST_WFI;
    end

    // The outstanding response lands this cycle, so it already holds a slot.
    w_room   = inflight_q ? (w_count < CNT_W'(FB_DEPTH - 1)) : !w_full;
    mem_ce   = w_flush | ((state_q == ST_FETCH) & ~wfi & w_room);
    mem_addr = w_flush ? w_tgt_line : line_q;
    line_d   = mem_ce ? (mem_addr + 1'b1) : line_q;

    // A response arriving alongside a flush belongs to the old stream.
    w_push = inflight_q & ~w_flush;

    ifu_idu_vld = (state_q == ST_FETCH) & ~w_empty;
    w_hs        = ifu_idu_vld & idu_ifu_rdy;
    w_last      = (slot_q == SLOT_W'(SLOTS - 1));
    w_pop       = w_hs & w_last & ~w_flush;

    slot_d = slot_q;
    if (w_flush) begin
      slot_d = w_tgt_slot;
    end else if (w_hs) begin
      slot_d = w_last ? '0 : (slot_q + 1'b1);
    end

    w_head_line = w_head[LINE_W-1:0];
    w_head_addr = w_head[ENT_W-1:LINE_W];
    w_pc_addr   = (ADDR_W'(w_head_addr) << LB_W) | (ADDR_W'(slot_q) << OFF_W);
    ifu_idu_ins = w_empty ? '0 : w_head_line[slot_q*INS_W +: INS_W];
    ifu_idu_pc  = w_empty ? '0 : PC_W'(w_pc_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      req_line_q <= '0;
      inflight_q <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      inflight_q <= mem_ce;
      slot_q     <= slot_d;
      if (mem_ce) req_line_q <= mem_addr;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_ins_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ins_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_hs && !(&perf_ins_q)) perf_ins_q <= perf_ins_q + 1'b1;
      if (ifu_idu_vld && !idu_ifu_rdy && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_ins_cnt   = perf_ins_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_pf.sv
//============================================================================
// tb_ifu_pf : directed self-checking bench for ifu_pf (default parameters)
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_ifu_pf;

  logic         clk;
  logic         rst_n;
  logic         start_vld;
  logic [11:0]  start_addr;
  logic         redir_vld;
  logic [11:0]  redir_addr;
  logic         wfi;
  logic         idu_ifu_rdy;
  logic         ifu_idu_vld;
  logic [63:0]  ifu_idu_ins;
  logic [31:0]  ifu_idu_pc;
  logic         mem_ce;
  logic [7:0]   mem_addr;
  logic [127:0] mem_dout;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]  perf_ins_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ifu_pf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_vld   (start_vld),
    .start_addr  (start_addr),
    .redir_vld   (redir_vld),
    .redir_addr  (redir_addr),
    .wfi         (wfi),
    .idu_ifu_rdy (idu_ifu_rdy),
    .ifu_idu_vld (ifu_idu_vld),
    .ifu_idu_ins (ifu_idu_ins),
    .ifu_idu_pc  (ifu_idu_pc),
    .mem_ce      (mem_ce),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_ins_cnt   (perf_ins_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction image: every instruction word encodes its own byte address.
  function automatic logic [63:0] ins_of(input logic [11:0] pc);
    return {32'hC0DE_5EED, 20'h0, pc};
  endfunction

  initial mem_dout = '0;
  always @(posedge clk) begin
    if (mem_ce) mem_dout <= {ins_of({mem_addr, 4'h8}), ins_of({mem_addr, 4'h0})};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_vld = 1'b0; start_addr = '0; redir_vld = 1'b0;
    redir_addr = '0; wfi = 1'b0; idu_ifu_rdy = 1'b0;
    cyc();
    #3;
    chk("reset_vld", 64'(ifu_idu_vld), 64'd0);
    chk("reset_mem_ce", 64'(mem_ce), 64'd0);
    chk("reset_pc", 64'(ifu_idu_pc), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_ins", ifu_idu_ins, 64'd0);
    cyc();
    rst_n = 1'b1;

    // Start at 0x018: first line 0x01, entered at slot 1
    cyc(); start_vld = 1'b1; start_addr = 12'h018; #3;
    chk("start_mem_ce", 64'(mem_ce), 64'd1);
    chk("start_mem_addr", 64'(mem_addr), 64'h01);
    chk("start_vld_T", 64'(ifu_idu_vld), 64'd0);
    cyc(); start_vld = 1'b0; #3;
    chk("start_vld_T1", 64'(ifu_idu_vld), 64'd0);
    chk("start_mem_addr_T1", 64'(mem_addr), 64'h02);
    cyc(); idu_ifu_rdy = 1'b1; #3;
    chk("start_vld_T2", 64'(ifu_idu_vld), 64'd1);
    chk("start_pc0", 64'(ifu_idu_pc), 64'h018);
    chk("start_ins0", ifu_idu_ins, ins_of(12'h018));
    cyc(); #3;
    chk("start_pc1", 64'(ifu_idu_pc), 64'h020);
    chk("start_ins1", ifu_idu_ins, ins_of(12'h020));
    cyc(); #3;
    chk("start_pc2", 64'(ifu_idu_pc), 64'h028);

    // Backpressure for 10 cycles: head stays at 0x030, buffer fills, requests stop
    cyc(); idu_ifu_rdy = 1'b0; #3;
    chk("bp_pc", 64'(ifu_idu_pc), 64'h030);
    for (int i = 1; i < 10; i++) begin
      cyc(); #3;
      chk("bp_vld_hold", 64'(ifu_idu_vld), 64'd1);
      chk("bp_pc_hold", 64'(ifu_idu_pc), 64'h030);
      chk("bp_ins_hold", ifu_idu_ins, ins_of(12'h030));
      if (i >= 2) chk("bp_full_no_ce", 64'(mem_ce), 64'd0);
    end
    cyc(); idu_ifu_rdy = 1'b1; #3;
    chk("bp_rel_pc", 64'(ifu_idu_pc), 64'h030);
    chk("bp_rel_ce", 64'(mem_ce), 64'd0);
    cyc(); #3;
    chk("bp_pop_pc", 64'(ifu_idu_pc), 64'h038);
    chk("bp_pop_same_cycle_ce", 64'(mem_ce), 64'd0);
    cyc(); #3;
    chk("bp_next_pc", 64'(ifu_idu_pc), 64'h040);
    chk("bp_reissue_ce", 64'(mem_ce), 64'd1);
    chk("bp_reissue_addr", 64'(mem_addr), 64'h07);

    // Redirect to 0x100 while line 0x07 is in flight
    cyc(); redir_vld = 1'b1; redir_addr = 12'h100; #3;
    chk("redir_ce", 64'(mem_ce), 64'd1);
    chk("redir_addr", 64'(mem_addr), 64'h10);
    cyc(); redir_vld = 1'b0; #3;
    chk("redir_vld_gap", 64'(ifu_idu_vld), 64'd0);
    chk("redir_next_addr", 64'(mem_addr), 64'h11);
    cyc(); #3;
    chk("redir_vld", 64'(ifu_idu_vld), 64'd1);
    chk("redir_pc", 64'(ifu_idu_pc), 64'h100);
    chk("redir_ins", ifu_idu_ins, ins_of(12'h100));
    cyc(); #3;
    chk("redir_pc1", 64'(ifu_idu_pc), 64'h108);
    cyc(); #3;
    chk("redir_pc2", 64'(ifu_idu_pc), 64'h110);

    // WFI mid-stream, resumed by a redirect to 0x040
    cyc(); wfi = 1'b1; #3;
    chk("wfi_ce", 64'(mem_ce), 64'd0);
    cyc(); wfi = 1'b0; #3;
    chk("wfi_vld", 64'(ifu_idu_vld), 64'd0);
    chk("wfi_ce_hold", 64'(mem_ce), 64'd0);
    cyc(); #3;
    chk("wfi_vld_hold", 64'(ifu_idu_vld), 64'd0);
    cyc(); redir_vld = 1'b1; redir_addr = 12'h040; #3;
    chk("wfi_exit_ce", 64'(mem_ce), 64'd1);
    chk("wfi_exit_addr", 64'(mem_addr), 64'h04);
    cyc(); redir_vld = 1'b0; #3;
    chk("wfi_exit_vld_gap", 64'(ifu_idu_vld), 64'd0);
    cyc(); #3;
    chk("wfi_resume_vld", 64'(ifu_idu_vld), 64'd1);
    chk("wfi_resume_pc", 64'(ifu_idu_pc), 64'h040);
    chk("wfi_resume_ins", ifu_idu_ins, ins_of(12'h040));
    cyc(); #3;
    chk("wfi_resume_pc1", 64'(ifu_idu_pc), 64'h048);

    // Address-space wrap from 0xFF8
    cyc(); start_vld = 1'b1; start_addr = 12'hFF8; #3;
    chk("wrap_addr0", 64'(mem_addr), 64'hFF);
    chk("wrap_ce0", 64'(mem_ce), 64'd1);
    cyc(); start_vld = 1'b0; #3;
    chk("wrap_addr1", 64'(mem_addr), 64'h00);
    cyc(); #3;
    chk("wrap_pc0", 64'(ifu_idu_pc), 64'hFF8);
    chk("wrap_ins0", ifu_idu_ins, ins_of(12'hFF8));
    cyc(); #3;
    chk("wrap_pc1", 64'(ifu_idu_pc), 64'h000);
    chk("wrap_ins1", ifu_idu_ins, ins_of(12'h000));

    // Reset mid-fetch
    cyc(); rst_n = 1'b0; #3;
    cyc(); rst_n = 1'b1; idu_ifu_rdy = 1'b0; #3;
    chk("rst_vld", 64'(ifu_idu_vld), 64'd0);
    chk("rst_ce", 64'(mem_ce), 64'd0);
    chk("rst_pc", 64'(ifu_idu_pc), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_ins", ifu_idu_ins, 64'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_ins", 64'(perf_ins_cnt), 64'd0);
    chk("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    // Redirect while idle is ignored
    cyc(); redir_vld = 1'b1; redir_addr = 12'h200; #3;
    chk("idle_redir_ce", 64'(mem_ce), 64'd0);
    cyc(); redir_vld = 1'b0; #3;
    chk("idle_redir_vld", 64'(ifu_idu_vld), 64'd0);
    chk("idle_redir_ce2", 64'(mem_ce), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
